// File: rtl/bcd_pkg.sv
// Shared definitions for the clock-datapath BCD counters and decoders.
//   bcd_t   : one BCD digit (4 bits)
//   bcd2_t  : two-digit BCD value {up, lo}
//   bcd_val : binary value of a two-digit BCD pair (8 bits, no overflow for 4-bit inputs)
package bcd_pkg;
    localparam int DIGIT_W   = 4;
    localparam int DIGIT_MAX = 9;
    localparam int MOD_MIN   = 2;
    localparam int MOD_MAX   = 99;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef struct packed {
        bcd_t up;
        bcd_t lo;
    } bcd2_t;

    localparam bcd_t DMAX = bcd_t'(DIGIT_MAX);

    function automatic logic [7:0] bcd_val(input bcd_t up, input bcd_t lo);
        return 8'(up) * 8'd10 + 8'(lo);
    endfunction
endpackage

// File: rtl/bcd_modcnt_if.sv
// Control/status bundle of one bcd_modcnt stage.
//   master: drives cnten, load, ldlow, ldup (and dir); observes digits, carry, loaderr
//   slave : the counter side
// Optional macro BCD_MODCNT_DOWN_EN adds the dir signal.
interface bcd_modcnt_if;
    import bcd_pkg::*;

    logic cnten;
`ifdef BCD_MODCNT_DOWN_EN
    logic dir;
`endif
    logic load;
    bcd_t ldlow;
    bcd_t ldup;
    bcd_t digitlow;
    bcd_t digitup;
    logic carry;
    logic loaderr;

    modport master (
        output cnten,
`ifdef BCD_MODCNT_DOWN_EN
        output dir,
`endif
        output load, ldlow, ldup,
        input  digitlow, digitup, carry, loaderr
    );

    modport slave (
        input  cnten,
`ifdef BCD_MODCNT_DOWN_EN
        input  dir,
`endif
        input  load, ldlow, ldup,
        output digitlow, digitup, carry, loaderr
    );
endinterface

// File: rtl/bcd_digit.sv
// One decade counter step.
//   cur  : current digit        en  : step this cycle
//   dir  : 0 up / 1 down        term: value at which an up step wraps to 0
//   reld : value loaded when a down step wraps below 0
//   nxt  : next digit value     wrap: this digit wraps on the step
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_t cur,
    input  logic en,
    input  logic dir,
    input  bcd_t term,
    input  bcd_t reld,
    output bcd_t nxt,
    output logic wrap
);
    always_comb begin
        wrap = 1'b0;
        nxt  = cur;
        if (en) begin
            if (dir) begin
                wrap = (cur == 4'd0);
                nxt  = wrap ? reld : cur - 4'd1;
            end else begin
                wrap = (cur == term);
                nxt  = wrap ? 4'd0 : cur + 4'd1;
            end
        end
    end
endmodule

// File: rtl/bcd_modcnt.sv
// Two-digit BCD modulo counter (0..MODULUS-1) with synchronous validated load
// and a combinational cascade carry/borrow.
//   CLK  : clock, rising edge       RST : async active-low reset
//   bus  : bcd_modcnt_if.slave (cnten, load, ldlow, ldup, [dir],
//          digitlow, digitup, carry, loaderr)
// Optional macro BCD_MODCNT_DOWN_EN enables dir and down counting.
module bcd_modcnt
    import bcd_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input logic         CLK,
    input logic         RST,
    bcd_modcnt_if.slave bus
);
    generate
        if (MODULUS < MOD_MIN || MODULUS > MOD_MAX) begin : g_bad_mod
            $fatal(1, "bcd_modcnt: MODULUS %0d outside 2..99", MODULUS);
        end
    endgenerate

    localparam bcd_t TUP  = bcd_t'((MODULUS - 1) / 10);
    localparam bcd_t TLOW = bcd_t'((MODULUS - 1) % 10);

    bcd2_t cnt_q;
    logic  err_q;
    logic  dn;
    logic  step;
    logic  ld_ok;
    bcd_t  lo_term, lo_reld, lo_nxt, up_nxt;
    logic  lo_wrap, up_wrap;

`ifdef BCD_MODCNT_DOWN_EN
    assign dn = bus.dir;
`else
    assign dn = 1'b0;
`endif

    assign step = bus.cnten & ~bus.load;

    // In the top decade the ones digit wraps at TLOW instead of 9 (up), and
    // a borrow out of 00 reloads it with TLOW (down).
    assign lo_term = (cnt_q.up == TUP)  ? TLOW : DMAX;
    assign lo_reld = (cnt_q.up == 4'd0) ? TLOW : DMAX;

    bcd_digit u_lo (
        .cur  (cnt_q.lo),
        .en   (step),
        .dir  (dn),
        .term (lo_term),
        .reld (lo_reld),
        .nxt  (lo_nxt),
        .wrap (lo_wrap)
    );

    bcd_digit u_up (
        .cur  (cnt_q.up),
        .en   (lo_wrap),
        .dir  (dn),
        .term (TUP),
        .reld (TUP),
        .nxt  (up_nxt),
        .wrap (up_wrap)
    );

    assign ld_ok = (bus.ldlow <= DMAX) && (bus.ldup <= DMAX) &&
                   (bcd_val(bus.ldup, bus.ldlow) <= 8'(MODULUS - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= bus.load & ~ld_ok;
            if (bus.load) begin
                if (ld_ok) cnt_q <= '{up: bus.ldup, lo: bus.ldlow};
            end else begin
                cnt_q <= '{up: up_nxt, lo: lo_nxt};
            end
        end
    end

    // The tens digit only wraps when the whole value sits at the terminal
    // for the current direction and a step is taken, which is the cascade pulse.
    assign bus.carry    = up_wrap;
    assign bus.digitlow = cnt_q.lo;
    assign bus.digitup  = cnt_q.up;
    assign bus.loaderr  = err_q;
endmodule

// File: tb/tb_bcd_modcnt.sv
// Directed bench for bcd_modcnt: reset, mod-60 up count, load priority and
// validation (mod-24), hold, async reset mid-count, 60-60-24 cascade and,
// with BCD_MODCNT_DOWN_EN, mod-12 down count.
module tb_bcd_modcnt;
    logic CLK;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    bcd_modcnt_if i60 ();
    bcd_modcnt_if i24 ();
    bcd_modcnt_if is  ();
    bcd_modcnt_if im  ();
    bcd_modcnt_if ih  ();

    bcd_modcnt #(.MODULUS(60)) u60  (.CLK(CLK), .RST(RST), .bus(i60));
    bcd_modcnt #(.MODULUS(24)) u24  (.CLK(CLK), .RST(RST), .bus(i24));
    bcd_modcnt #(.MODULUS(60)) usec (.CLK(CLK), .RST(RST), .bus(is));
    bcd_modcnt #(.MODULUS(60)) umin (.CLK(CLK), .RST(RST), .bus(im));
    bcd_modcnt #(.MODULUS(24)) uhr  (.CLK(CLK), .RST(RST), .bus(ih));

    assign im.cnten = is.carry;
    assign ih.cnten = im.carry;

`ifdef BCD_MODCNT_DOWN_EN
    bcd_modcnt_if i12 ();
    bcd_modcnt #(.MODULUS(12)) u12 (.CLK(CLK), .RST(RST), .bus(i12));
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0;
        i60.cnten = 0; i60.load = 0; i60.ldlow = 0; i60.ldup = 0;
        i24.cnten = 0; i24.load = 0; i24.ldlow = 0; i24.ldup = 0;
        is.cnten  = 0; is.load  = 0; is.ldlow  = 0; is.ldup  = 0;
        im.load   = 0; im.ldlow = 0; im.ldup   = 0;
        ih.load   = 0; ih.ldlow = 0; ih.ldup   = 0;
`ifdef BCD_MODCNT_DOWN_EN
        i60.dir = 0; i24.dir = 0; is.dir = 0; im.dir = 0; ih.dir = 0;
        i12.cnten = 0; i12.load = 0; i12.ldlow = 0; i12.ldup = 0; i12.dir = 0;
`endif
        #1;
        chk("rst_val", {i60.digitup, i60.digitlow}, 'h00);
        chk("rst_err", i60.loaderr, 0);
        chk("rst_cy",  i60.carry, 0);
        #11 RST = 1'b1;

        // mod-60 up count through the full range and back to 00
        i60.cnten = 1;
        for (int i = 0; i < 60; i++) begin
            #1;
            chk("up_lo", i60.digitlow, i % 10);
            chk("up_hi", i60.digitup,  i / 10);
            chk("up_cy", i60.carry, (i == 59) ? 1 : 0);
            tick();
        end
        chk("up_wrap", {i60.digitup, i60.digitlow}, 'h00);
        i60.cnten = 0;

        // mod-24 load priority and validation
        i24.load = 1; i24.ldup = 2; i24.ldlow = 3;
        tick();
        chk("ld23", {i24.digitup, i24.digitlow}, 'h23);
        i24.ldup = 1; i24.ldlow = 8; i24.cnten = 1;
        #1 chk("ld_cy0", i24.carry, 0);
        tick();
        chk("ld18", {i24.digitup, i24.digitlow}, 'h18);
        chk("ld18_err", i24.loaderr, 0);
        i24.cnten = 0; i24.ldup = 2; i24.ldlow = 5;
        tick();
        chk("ld25_val", {i24.digitup, i24.digitlow}, 'h18);
        chk("ld25_err", i24.loaderr, 1);
        i24.load = 0;
        tick();
        chk("err_clr", i24.loaderr, 0);
        i24.load = 1; i24.ldup = 0; i24.ldlow = 4'hA;
        tick();
        chk("ld0A_val", {i24.digitup, i24.digitlow}, 'h18);
        chk("ld0A_err", i24.loaderr, 1);
        i24.ldup = 2; i24.ldlow = 4;
        tick();
        chk("ld24_val", {i24.digitup, i24.digitlow}, 'h18);
        chk("ld24_err", i24.loaderr, 1);
        i24.ldup = 2; i24.ldlow = 3;
        tick();
        chk("ld23b", {i24.digitup, i24.digitlow}, 'h23);
        chk("ld23b_err", i24.loaderr, 0);
        i24.load = 0; i24.cnten = 1;
        #1 chk("m24_cy", i24.carry, 1);
        tick();
        chk("m24_wrap", {i24.digitup, i24.digitlow}, 'h00);
        i24.cnten = 0;

        // hold at 45
        i60.load = 1; i60.ldup = 4; i60.ldlow = 5;
        tick();
        i60.load = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("hold_val", {i60.digitup, i60.digitlow}, 'h45);
            chk("hold_cy",  i60.carry, 0);
            chk("hold_err", i60.loaderr, 0);
            tick();
        end

        // async reset mid-count at 37, with a pending loaderr on u24
        i60.load = 1; i60.ldup = 3; i60.ldlow = 7;
        i24.load = 1; i24.ldup = 2; i24.ldlow = 5;
        tick();
        chk("pre_rst", {i60.digitup, i60.digitlow}, 'h37);
        chk("pre_err", i24.loaderr, 1);
        i60.load = 0; i24.load = 0; i60.cnten = 1;
        #2 RST = 1'b0;
        #1;
        chk("arst_val", {i60.digitup, i60.digitlow}, 'h00);
        chk("arst_err", i24.loaderr, 0);
        @(negedge CLK);
        RST = 1'b1;
        #1 chk("rel_val", {i60.digitup, i60.digitlow}, 'h00);
        tick();
        chk("res_01", {i60.digitup, i60.digitlow}, 'h01);
        tick();
        chk("res_02", {i60.digitup, i60.digitlow}, 'h02);
        i60.cnten = 0;

        // 60-60-24 cascade from 23:59:58
        is.load = 1; is.ldup = 5; is.ldlow = 8;
        im.load = 1; im.ldup = 5; im.ldlow = 9;
        ih.load = 1; ih.ldup = 2; ih.ldlow = 3;
        tick();
        is.load = 0; im.load = 0; ih.load = 0; is.cnten = 1;
        #1;
        chk("cas58", {ih.digitup, ih.digitlow, im.digitup, im.digitlow, is.digitup, is.digitlow}, 'h235958);
        chk("cas58_hcy", ih.carry, 0);
        tick();
        chk("cas59", {ih.digitup, ih.digitlow, im.digitup, im.digitlow, is.digitup, is.digitlow}, 'h235959);
        chk("cas59_scy", is.carry, 1);
        chk("cas59_mcy", im.carry, 1);
        chk("cas59_hcy", ih.carry, 1);
        tick();
        chk("cas00", {ih.digitup, ih.digitlow, im.digitup, im.digitlow, is.digitup, is.digitlow}, 'h000000);
        chk("cas00_hcy", ih.carry, 0);
        is.cnten = 0;

`ifdef BCD_MODCNT_DOWN_EN
        // mod-12 down count from 01
        begin
            int exp_v [4] = '{'h01, 'h00, 'h11, 'h10};
            int exp_c [4] = '{0, 1, 0, 0};
            i12.dir = 1; i12.load = 1; i12.ldup = 0; i12.ldlow = 1;
            tick();
            i12.load = 0; i12.cnten = 1;
            for (int i = 0; i < 4; i++) begin
                #1;
                chk("dn_val", {i12.digitup, i12.digitlow}, exp_v[i]);
                chk("dn_cy",  i12.carry, exp_c[i]);
                tick();
            end
            i12.cnten = 0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
